camera_capture: RTL and testbench
=================================

// Module: camera_capture
// PURPOSE
// - Upstream stage of the colour classifier. Deserialises the OV7670 RGB565 byte stream
//   (2 bytes/pixel) into RGB332 pixels and writes them into the 176x144 frame buffer.
// - The VGA/classifier side reads the frame buffer back as its 8-bit PIXEL_IN.
// - All bright-white 0xFF and colour-bit encodings must match what that stage decodes.
// PARAMETERS
// - SCREEN_WIDTH   176  pixels per line written; extra pixels are dropped
// - SCREEN_HEIGHT  144  lines per frame written; extra lines are dropped
// - ADDR_W         15   frame-buffer address width (>= clog2(176*144)=15)
// PORTS
// - CLK            in   1       camera pixel clock (PCLK); the only clock
// - RESET          in   1       asynchronous, active-high reset
// - CAM_VSYNC      in   1       high = vertical blank
// - CAM_HREF       in   1       high = valid bytes on CAM_DATA
// - CAM_DATA       in   8       camera byte, sampled on posedge CLK
// - W_EN           out  1       frame-buffer write strobe, one cycle per pixel
// - WRITE_ADDRESS  out  ADDR_W  y*SCREEN_WIDTH + x
// - PIXEL_OUT      out  8       RGB332 {R[2:0],G[2:0],B[1:0]}
// - FRAME_DONE     out  1       one-cycle pulse at end of an active frame
// - LINE_SHORT     out  1       sticky: a line ended with x<SCREEN_WIDTH this frame
// - ODD_BYTE       out  1       sticky: HREF fell after a lone high byte this frame
// BEHAVIOUR
// - Reset: all outputs 0; state VBLANK; x=y=0; hi-byte latch 0.
// - FSM states: VBLANK, WAIT_LINE, HI, LO. Inputs are sampled every posedge CLK.
// - Any state, CAM_VSYNC=1:
//   - go VBLANK; x=y=0.
//   - If not already in VBLANK and y>0, pulse FRAME_DONE next cycle.
//   - LINE_SHORT and ODD_BYTE clear on this VSYNC entry (after the pulse cycle).
// - VBLANK -> WAIT_LINE when CAM_VSYNC=0.
// - WAIT_LINE or HI, HREF=1: latch CAM_DATA as high byte -> LO.
// - LO, HREF=1: form the pixel -> HI.
//   - With hi=R[4:0]G[5:3] and lo=G[2:0]B[4:0]:
//     PIXEL_OUT = {hi[7:5], hi[2:0], lo[4:3]}.
//   - If x<SCREEN_WIDTH and y<SCREEN_HEIGHT: W_EN=1 next cycle with the registered
//     address/pixel (latency 1 cycle after the low byte).
//   - x increments and saturates at SCREEN_WIDTH.
// - HI or LO, HREF=0 (end of line):
//   - If x<SCREEN_WIDTH, set LINE_SHORT.
//   - In LO, set ODD_BYTE and discard the partial pixel.
//   - If x>0, y increments (saturates at SCREEN_HEIGHT); then x=0 -> WAIT_LINE.
// - Address arithmetic is done in ADDR_W bits; max address 25343, never wraps.
// - W_EN is 0 in every cycle not described above. Writes never occur in VBLANK.
// - Async RESET mid-line or mid-pixel aborts the line and drops the pending pixel;
//   no W_EN in the reset cycle.
// - VSYNC takes priority over HREF in the same cycle.
// STRUCTURE
// - Shared package: SCREEN_WIDTH/HEIGHT, ADDR_W, FSM state encoding, RGB332 field
//   positions, so the classifier uses identical constants.
// - Sub-module rgb565_to_rgb332 (pure combinational pack); FSM and counters stay in
//   camera_capture.
// TESTING
// - Bytes F8,00 at x=0,y=0 -> W_EN one cycle, WRITE_ADDRESS 0, PIXEL_OUT E0.
// - Bytes 07,E0 -> 1C; bytes 00,1F -> 03; bytes FF,FF -> FF.
// - Full frame of 144 lines x 352 bytes -> 25344 writes; last address 25343;
//   FRAME_DONE pulses once on VSYNC rise; both flags 0.
// - Line of 360 bytes -> only 176 writes, no address overflow. 150 lines -> writes stop
//   at y=143.
// - HREF falls after 101 bytes -> 50 writes, ODD_BYTE=1, LINE_SHORT=1; both clear after
//   next VSYNC.
// - RESET asserted between hi and lo byte -> no W_EN; outputs 0 immediately; next frame
//   starts at address 0.

Source files
------------

// File: rtl/camera_capture_pkg.sv
// Shared constants for the camera capture path and the downstream colour classifier.
// Frame geometry, frame-buffer address width, capture FSM encoding and the RGB332
// field layout live here so both ends of the frame buffer agree on them.
package camera_capture_pkg;

    localparam int SCREEN_WIDTH  = 176;
    localparam int SCREEN_HEIGHT = 144;
    localparam int ADDR_W        = 15;
    localparam int MAX_ADDR      = SCREEN_WIDTH * SCREEN_HEIGHT - 1;

    // Counter widths: x must reach SCREEN_WIDTH and y must reach SCREEN_HEIGHT,
    // because both counters saturate one past the last written position.
    localparam int X_W = 8;
    localparam int Y_W = 8;

    // RGB332 layout {R[2:0], G[2:0], B[1:0]}; 0xFF is bright white.
    localparam int R_HI = 7;
    localparam int R_LO = 5;
    localparam int G_HI = 4;
    localparam int G_LO = 2;
    localparam int B_HI = 1;
    localparam int B_LO = 0;

    typedef enum logic [1:0] {
        ST_VBLANK    = 2'd0,
        ST_WAIT_LINE = 2'd1,
        ST_HI        = 2'd2,
        ST_LO        = 2'd3
    } cap_state_t;

    // Linear frame-buffer address y*SCREEN_WIDTH + x, computed in ADDR_W bits.
    function automatic logic [ADDR_W-1:0] pixel_addr(input logic [X_W-1:0] x,
                                                     input logic [Y_W-1:0] y);
        return ADDR_W'(y) * ADDR_W'(SCREEN_WIDTH) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/camera_capture_if.sv
// Camera byte stream in, frame-buffer write port and status flags out.
// slave  : the capture block (samples CAM_*, drives the write port and flags)
// master : the camera / test side (drives CAM_*, observes the write port)
interface camera_capture_if;
    import camera_capture_pkg::*;

    logic              CAM_VSYNC;
    logic              CAM_HREF;
    logic [7:0]        CAM_DATA;
    logic              W_EN;
    logic [ADDR_W-1:0] WRITE_ADDRESS;
    logic [7:0]        PIXEL_OUT;
    logic              FRAME_DONE;
    logic              LINE_SHORT;
    logic              ODD_BYTE;

    modport master (
        output CAM_VSYNC, CAM_HREF, CAM_DATA,
        input  W_EN, WRITE_ADDRESS, PIXEL_OUT, FRAME_DONE, LINE_SHORT, ODD_BYTE
    );

    modport slave (
        input  CAM_VSYNC, CAM_HREF, CAM_DATA,
        output W_EN, WRITE_ADDRESS, PIXEL_OUT, FRAME_DONE, LINE_SHORT, ODD_BYTE
    );

endinterface

// File: rtl/camera_capture_rgb565_to_rgb332.sv
// Packs one RGB565 pixel, received as two camera bytes, into RGB332.
//   hi    : first byte  = R[4:0] G[5:3]
//   lo    : second byte = G[2:0] B[4:0]
//   pixel : {R[4:2], G[5:3], B[4:3]} -- the top bits of each channel
module rgb565_to_rgb332
    import camera_capture_pkg::*;
(
    input  logic [7:0] hi,
    input  logic [7:0] lo,
    output logic [7:0] pixel
);

    always_comb begin
        pixel             = '0;
        pixel[R_HI:R_LO]  = hi[7:5];
        pixel[G_HI:G_LO]  = hi[2:0];
        pixel[B_HI:B_LO]  = lo[4:3];
    end

endmodule

// File: rtl/camera_capture.sv
// OV7670 capture: deserialises the RGB565 byte stream (two bytes per pixel, sampled
// on PCLK) into RGB332 pixels and writes them into the 176x144 frame buffer.
//   CLK   : camera pixel clock, the only clock
//   RESET : asynchronous, active-high
//   bus   : camera inputs (CAM_VSYNC/HREF/DATA) and the registered write port
//           (W_EN, WRITE_ADDRESS, PIXEL_OUT) plus FRAME_DONE / LINE_SHORT / ODD_BYTE
// All outputs are registered; a pixel appears one cycle after its low byte.
module camera_capture
    import camera_capture_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET,
    camera_capture_if.slave  bus
);

    cap_state_t        state, state_n;
    logic [X_W-1:0]    x, x_n;
    logic [Y_W-1:0]    y, y_n;
    logic [7:0]        hi_byte, hi_n;
    logic              w_en, w_en_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic [7:0]        pix, pix_n;
    logic              done, done_n;
    logic              line_short, short_n;
    logic              odd_byte, odd_n;
    logic              eol;
    logic [7:0]        pix_packed;

    rgb565_to_rgb332 u_pack (
        .hi    (hi_byte),
        .lo    (bus.CAM_DATA),
        .pixel (pix_packed)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= ST_VBLANK;
            x          <= '0;
            y          <= '0;
            hi_byte    <= '0;
            w_en       <= 1'b0;
            addr       <= '0;
            pix        <= '0;
            done       <= 1'b0;
            line_short <= 1'b0;
            odd_byte   <= 1'b0;
        end else begin
            state      <= state_n;
            x          <= x_n;
            y          <= y_n;
            hi_byte    <= hi_n;
            w_en       <= w_en_n;
            addr       <= addr_n;
            pix        <= pix_n;
            done       <= done_n;
            line_short <= short_n;
            odd_byte   <= odd_n;
        end
    end

    always_comb begin
        state_n = state;
        x_n     = x;
        y_n     = y;
        hi_n    = hi_byte;
        w_en_n  = 1'b0;
        addr_n  = addr;
        pix_n   = pix;
        done_n  = 1'b0;
        eol     = 1'b0;
        // Flags survive the VSYNC entry edge so they are still visible alongside the
        // FRAME_DONE pulse; they clear on the first edge spent in VBLANK.
        short_n = (state == ST_VBLANK) ? 1'b0 : line_short;
        odd_n   = (state == ST_VBLANK) ? 1'b0 : odd_byte;

        if (bus.CAM_VSYNC) begin
            // VSYNC overrides HREF: any byte in this cycle is ignored.
            state_n = ST_VBLANK;
            x_n     = '0;
            y_n     = '0;
            if (state != ST_VBLANK && y != '0)
                done_n = 1'b1;
        end else begin
            case (state)
                ST_VBLANK: state_n = ST_WAIT_LINE;
                ST_WAIT_LINE: begin
                    if (bus.CAM_HREF) begin
                        hi_n    = bus.CAM_DATA;
                        state_n = ST_LO;
                    end
                end
                ST_HI: begin
                    if (bus.CAM_HREF) begin
                        hi_n    = bus.CAM_DATA;
                        state_n = ST_LO;
                    end else begin
                        eol = 1'b1;
                    end
                end
                ST_LO: begin
                    if (bus.CAM_HREF) begin
                        if (x < X_W'(SCREEN_WIDTH) && y < Y_W'(SCREEN_HEIGHT)) begin
                            w_en_n = 1'b1;
                            addr_n = pixel_addr(x, y);
                            pix_n  = pix_packed;
                        end
                        if (x < X_W'(SCREEN_WIDTH))
                            x_n = x + X_W'(1);
                        state_n = ST_HI;
                    end else begin
                        // Line ended between the two bytes: the half pixel is dropped.
                        eol   = 1'b1;
                        odd_n = 1'b1;
                    end
                end
                default: state_n = ST_VBLANK;
            endcase

            if (eol) begin
                if (x < X_W'(SCREEN_WIDTH))
                    short_n = 1'b1;
                // An empty line (no complete pixel) does not consume a row.
                if (x != '0 && y < Y_W'(SCREEN_HEIGHT))
                    y_n = y + Y_W'(1);
                x_n     = '0;
                state_n = ST_WAIT_LINE;
            end
        end
    end

    assign bus.W_EN          = w_en;
    assign bus.WRITE_ADDRESS = addr;
    assign bus.PIXEL_OUT     = pix;
    assign bus.FRAME_DONE    = done;
    assign bus.LINE_SHORT    = line_short;
    assign bus.ODD_BYTE      = odd_byte;

endmodule

// File: tb/tb_camera_capture.sv
module tb_camera_capture;
    import camera_capture_pkg::*;

    typedef struct {
        logic [7:0] hi;
        logic [7:0] lo;
        logic [7:0] pix;
    } vec_t;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    // Write-port monitor, sampled on the falling edge.
    int                wr_cnt   = 0;
    int                fd_cnt   = 0;
    int                over_cnt = 0;
    logic [ADDR_W-1:0] last_addr = '0;

    camera_capture_if bus();

    camera_capture dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.W_EN === 1'b1) begin
            wr_cnt    <= wr_cnt + 1;
            last_addr <= bus.WRITE_ADDRESS;
            if (bus.WRITE_ADDRESS > ADDR_W'(MAX_ADDR))
                over_cnt <= over_cnt + 1;
        end
        if (bus.FRAME_DONE === 1'b1)
            fd_cnt <= fd_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // n bytes with HREF high, then one cycle of HREF low to end the line.
    task automatic send_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            bus.CAM_HREF = 1'b1;
            bus.CAM_DATA = 8'(i);
            tick();
        end
        bus.CAM_HREF = 1'b0;
        tick();
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, " W_EN"},          32'(bus.W_EN),          32'h0);
        chk({tag, " WRITE_ADDRESS"}, 32'(bus.WRITE_ADDRESS), 32'h0);
        chk({tag, " PIXEL_OUT"},     32'(bus.PIXEL_OUT),     32'h0);
        chk({tag, " FRAME_DONE"},    32'(bus.FRAME_DONE),    32'h0);
        chk({tag, " LINE_SHORT"},    32'(bus.LINE_SHORT),    32'h0);
        chk({tag, " ODD_BYTE"},      32'(bus.ODD_BYTE),      32'h0);
    endtask

    initial begin
        vec_t vecs[6];
        int   base;
        int   fd_base;

        vecs[0] = '{hi: 8'hF8, lo: 8'h00, pix: 8'hE0};
        vecs[1] = '{hi: 8'h07, lo: 8'hE0, pix: 8'h1C};
        vecs[2] = '{hi: 8'h00, lo: 8'h1F, pix: 8'h03};
        vecs[3] = '{hi: 8'hFF, lo: 8'hFF, pix: 8'hFF};
        vecs[4] = '{hi: 8'hA5, lo: 8'h5A, pix: 8'hB7};
        vecs[5] = '{hi: 8'h12, lo: 8'h34, pix: 8'h0A};

        rst           = 1'b1;
        bus.CAM_VSYNC = 1'b0;
        bus.CAM_HREF  = 1'b0;
        bus.CAM_DATA  = 8'h00;
        tick();
        tick();
        chk_outputs_zero("reset");
        rst = 1'b0;
        tick();  // VBLANK -> WAIT_LINE

        // Pixel packing table, one line, addresses 0..5.
        for (int i = 0; i < 6; i++) begin
            bus.CAM_HREF = 1'b1;
            bus.CAM_DATA = vecs[i].hi;
            tick();
            chk($sformatf("vec%0d w_en after hi", i), 32'(bus.W_EN), 32'h0);
            bus.CAM_DATA = vecs[i].lo;
            tick();
            chk($sformatf("vec%0d w_en", i), 32'(bus.W_EN), 32'h1);
            chk($sformatf("vec%0d addr", i), 32'(bus.WRITE_ADDRESS), 32'(i));
            chk($sformatf("vec%0d pixel", i), 32'(bus.PIXEL_OUT), 32'(vecs[i].pix));
        end
        bus.CAM_HREF = 1'b0;
        tick();
        chk("short line w_en", 32'(bus.W_EN), 32'h0);
        chk("short line LINE_SHORT", 32'(bus.LINE_SHORT), 32'h1);
        chk("short line ODD_BYTE", 32'(bus.ODD_BYTE), 32'h0);
        bus.CAM_VSYNC = 1'b1;
        tick();
        chk("vsync1 FRAME_DONE", 32'(bus.FRAME_DONE), 32'h1);
        chk("vsync1 LINE_SHORT held", 32'(bus.LINE_SHORT), 32'h1);
        bus.CAM_VSYNC = 1'b0;
        tick();
        chk("vsync1 FRAME_DONE drop", 32'(bus.FRAME_DONE), 32'h0);
        chk("vsync1 LINE_SHORT clear", 32'(bus.LINE_SHORT), 32'h0);

        // Full frame: first line over-long, 150 lines in total.
        base    = wr_cnt;
        fd_base = fd_cnt;
        send_bytes(360);
        chk("long line writes", 32'(wr_cnt - base), 32'd176);
        for (int l = 1; l < 150; l++)
            send_bytes(352);
        chk("frame writes", 32'(wr_cnt - base), 32'd25344);
        chk("frame last addr", 32'(last_addr), 32'd25343);
        chk("frame addr overflow", 32'(over_cnt), 32'd0);
        chk("frame LINE_SHORT", 32'(bus.LINE_SHORT), 32'h0);
        chk("frame ODD_BYTE", 32'(bus.ODD_BYTE), 32'h0);
        chk("frame no early done", 32'(fd_cnt - fd_base), 32'd0);
        bus.CAM_VSYNC = 1'b1;
        repeat (3) tick();
        bus.CAM_VSYNC = 1'b0;
        tick();
        chk("frame done pulses", 32'(fd_cnt - fd_base), 32'd1);

        // Odd byte count: 101 bytes.
        base = wr_cnt;
        send_bytes(101);
        chk("odd writes", 32'(wr_cnt - base), 32'd50);
        chk("odd ODD_BYTE", 32'(bus.ODD_BYTE), 32'h1);
        chk("odd LINE_SHORT", 32'(bus.LINE_SHORT), 32'h1);
        bus.CAM_VSYNC = 1'b1;
        tick();
        chk("odd FRAME_DONE", 32'(bus.FRAME_DONE), 32'h1);
        chk("odd ODD_BYTE held", 32'(bus.ODD_BYTE), 32'h1);
        bus.CAM_VSYNC = 1'b0;
        tick();
        chk("odd ODD_BYTE clear", 32'(bus.ODD_BYTE), 32'h0);
        chk("odd LINE_SHORT clear", 32'(bus.LINE_SHORT), 32'h0);

        // Async reset between hi and lo byte.
        for (int i = 0; i < 7; i++) begin
            bus.CAM_HREF = 1'b1;
            bus.CAM_DATA = 8'hFF;
            tick();
        end
        base = wr_cnt;
        #1 rst = 1'b1;
        #1;
        chk_outputs_zero("async reset");
        tick();
        chk("reset cycle w_en", 32'(bus.W_EN), 32'h0);
        chk("reset no writes", 32'(wr_cnt - base), 32'd0);
        rst          = 1'b0;
        bus.CAM_HREF = 1'b0;
        tick();
        bus.CAM_HREF = 1'b1;
        bus.CAM_DATA = 8'hF8;
        tick();
        bus.CAM_DATA = 8'h00;
        tick();
        chk("post reset w_en", 32'(bus.W_EN), 32'h1);
        chk("post reset addr", 32'(bus.WRITE_ADDRESS), 32'h0);
        chk("post reset pixel", 32'(bus.PIXEL_OUT), 32'hE0);
        bus.CAM_HREF = 1'b0;
        tick();

        // VSYNC wins over HREF.
        bus.CAM_VSYNC = 1'b1;
        bus.CAM_HREF  = 1'b1;
        bus.CAM_DATA  = 8'hFF;
        tick();
        chk("vsync+href done", 32'(bus.FRAME_DONE), 32'h1);
        chk("vsync+href w_en", 32'(bus.W_EN), 32'h0);
        tick();
        chk("vblank href w_en", 32'(bus.W_EN), 32'h0);
        chk("vblank done once", 32'(bus.FRAME_DONE), 32'h0);
        chk("vblank LINE_SHORT clear", 32'(bus.LINE_SHORT), 32'h0);
        bus.CAM_VSYNC = 1'b0;
        bus.CAM_HREF  = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
